// File: rtl/cc_matrix_row_scan_pkg.sv
// Shared definitions for the LED matrix row scanner: scan FSM encoding and
// default show/blank durations, also used by the game clock-divider blocks.
package cc_matrix_row_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHOW,
    ST_BLANK
  } scan_state_e;

  localparam int unsigned DEF_SHOW_CYCLES  = 5000;
  localparam int unsigned DEF_BLANK_CYCLES = 16;
  localparam int unsigned DEF_NROWS        = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cc_matrix_row_scan_if.sv
// Frame input handshake plus row-drive outputs of the matrix scanner.
interface cc_matrix_row_scan_if
  import cc_matrix_row_scan_pkg::*;
#(
  parameter int unsigned NROWS = DEF_NROWS
);

  logic [8*NROWS-1:0] frame;
  logic               frame_valid;
  logic               frame_ready;
  logic [7:0]         row_data;
  logic               blank;
  logic [NROWS-1:0]   row_sel;
  logic               frame_done;

  modport master (
    output frame, frame_valid,
    input  frame_ready, row_data, blank, row_sel, frame_done
  );

  modport slave (
    input  frame, frame_valid,
    output frame_ready, row_data, blank, row_sel, frame_done
  );

endinterface

// File: rtl/cc_frame_dbuf.sv
// Double frame buffer: shadow accepts new frames, active feeds the scanner;
// the two only swap when the scanner signals a frame boundary.
module cc_frame_dbuf
  import cc_matrix_row_scan_pkg::*;
#(
  parameter int unsigned NROWS = DEF_NROWS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [8*NROWS-1:0] frame,
  input  logic               frame_valid,
  output logic               frame_ready,
  input  logic               swap_req,
  output logic               shadow_full,
  output logic [8*NROWS-1:0] active
);

  logic [8*NROWS-1:0] shadow;
  logic               accept;
  logic               do_swap;

  assign frame_ready = ~shadow_full;
  assign accept      = frame_valid & frame_ready;
  assign do_swap     = swap_req & shadow_full;

  // NOTE: both buffers sit in the reset branch on purpose; a reset mid-scan
  // must discard any frame content, not just the control state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow      <= '0;
      active      <= '0;
      shadow_full <= 1'b0;
    end else begin
      // Swap reads the old shadow, so a same-cycle accept cannot leak into active.
      if (do_swap) active <= shadow;
      if (accept)  shadow <= frame;
      if (accept)       shadow_full <= 1'b1;
      else if (do_swap) shadow_full <= 1'b0;
    end
  end

endmodule

// File: rtl/cc_matrix_row_scan.sv
// Row-at-a-time scanner for an 8-column LED matrix: LOAD, SHOW and BLANK per
// row, with dead time so a row switch never lights stale pixels.
module cc_matrix_row_scan
  import cc_matrix_row_scan_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES  = DEF_SHOW_CYCLES,
  parameter int unsigned BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int unsigned NROWS        = DEF_NROWS
) (
  input  logic                  CC_MATRIXSCAN_CLOCK_50,
  input  logic                  CC_MATRIXSCAN_RESET_InLow,
  cc_matrix_row_scan_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(max_u(SHOW_CYCLES, BLANK_CYCLES) + 1);
  localparam int unsigned ROW_W = (NROWS > 1) ? $clog2(NROWS) : 1;

  logic clk;
  logic rst_n;
  assign clk   = CC_MATRIXSCAN_CLOCK_50;
  assign rst_n = CC_MATRIXSCAN_RESET_InLow;

  scan_state_e        state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [ROW_W-1:0]   row, row_next;
  logic               swap_req;
  logic               frame_end;
  logic               shadow_full;
  logic [8*NROWS-1:0] active;

  logic [7:0]         row_data;
  logic [NROWS-1:0]   row_sel;
  logic               blank;
  logic               frame_done;

  cc_frame_dbuf #(.NROWS(NROWS)) u_dbuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame       (bus.frame),
    .frame_valid (bus.frame_valid),
    .frame_ready (bus.frame_ready),
    .swap_req    (swap_req),
    .shadow_full (shadow_full),
    .active      (active)
  );

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    row_next   = row;
    swap_req   = 1'b0;
    frame_end  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (shadow_full) begin
          swap_req   = 1'b1;
          row_next   = '0;
          cnt_next   = '0;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_next   = CNT_W'(SHOW_CYCLES - 1);
        state_next = ST_SHOW;
      end
      ST_SHOW: begin
        if (cnt == '0) begin
          cnt_next   = CNT_W'(BLANK_CYCLES - 1);
          state_next = ST_BLANK;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      ST_BLANK: begin
        if (cnt == '0) begin
          cnt_next   = '0;
          state_next = ST_LOAD;
          if (row == ROW_W'(NROWS - 1)) begin
            row_next  = '0;
            frame_end = 1'b1;
            swap_req  = 1'b1;
          end else begin
            row_next = row + 1'b1;
          end
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      row        <= '0;
      row_data   <= '0;
      row_sel    <= '0;
      blank      <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      row        <= row_next;
      // Registered from next state so the mux select never glitches on decode.
      blank      <= (state_next != ST_SHOW);
      frame_done <= frame_end;
      if (state == ST_LOAD) begin
        row_data <= active[8*int'(row) +: 8];
        row_sel  <= NROWS'(1) << row;
      end else if (state_next != ST_SHOW) begin
        row_sel  <= '0;
      end
    end
  end

  assign bus.row_data   = row_data;
  assign bus.row_sel    = row_sel;
  assign bus.blank      = blank;
  assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_cc_matrix_row_scan.sv
// Self-checking bench for cc_matrix_row_scan: directed and random frames
// compared every cycle against a time-indexed reference model.
module tb_cc_matrix_row_scan;

  localparam int SHOW   = 4;
  localparam int BLANK  = 2;
  localparam int NR     = 8;
  localparam int ROWP   = 1 + SHOW + BLANK;
  localparam int FRAMEP = NR * ROWP;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  cc_matrix_row_scan_if #(.NROWS(NR)) bus ();

  cc_matrix_row_scan #(
    .SHOW_CYCLES  (SHOW),
    .BLANK_CYCLES (BLANK),
    .NROWS        (NR)
  ) dut (
    .CC_MATRIXSCAN_CLOCK_50    (clk),
    .CC_MATRIXSCAN_RESET_InLow (rst_n),
    .bus                       (bus)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: scan position is just "cycles since the first LOAD".
  bit              m_scanning;
  int              m_k;
  bit              m_full;
  logic [8*NR-1:0] m_shadow;
  logic [8*NR-1:0] m_active;
  logic [7:0]      m_data;
  bit              acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic          exp_blank;
    logic [NR-1:0] exp_sel;
    logic          exp_done;
    int            ph;
    int            r;
    exp_blank = 1'b1;
    exp_sel   = '0;
    exp_done  = 1'b0;
    if (m_scanning) begin
      ph = m_k % ROWP;
      r  = (m_k / ROWP) % NR;
      if (ph >= 1 && ph <= SHOW) begin
        exp_blank = 1'b0;
        exp_sel   = NR'(1) << r;
      end
      exp_done = (m_k > 0) && (m_k % FRAMEP == 0);
    end
    check("blank",       64'(bus.blank),       64'(exp_blank));
    check("row_sel",     64'(bus.row_sel),     64'(exp_sel));
    check("row_data",    64'(bus.row_data),    64'(m_data));
    check("frame_ready", 64'(bus.frame_ready), 64'(!m_full));
    check("frame_done",  64'(bus.frame_done),  64'(exp_done));
    if (bus.blank === 1'b0) check("onehot_when_shown", 64'($onehot(bus.row_sel)), 64'd1);
  endtask

  task automatic model_reset();
    m_scanning = 1'b0;
    m_k        = 0;
    m_full     = 1'b0;
    m_shadow   = '0;
    m_active   = '0;
    m_data     = '0;
  endtask

  task automatic do_reset(input int n);
    rst_n           = 1'b0;
    bus.frame_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      model_reset();
      check_outputs();
    end
    rst_n = 1'b1;
  endtask

  // One clock: drive inputs, advance the model across the edge, compare.
  task automatic step(input logic valid, input logic [8*NR-1:0] frame, output bit accepted);
    bit end_frame;
    bit start;
    bit swap;
    bus.frame_valid = valid;
    bus.frame       = frame;
    accepted  = valid && !m_full;
    end_frame = m_scanning && (m_k % FRAMEP == FRAMEP - 1);
    start     = !m_scanning && m_full;
    swap      = m_full && (start || end_frame);
    if (swap) begin
      m_active = m_shadow;
      m_full   = 1'b0;
    end
    if (accepted) begin
      m_shadow = frame;
      m_full   = 1'b1;
    end
    if (start) begin
      m_scanning = 1'b1;
      m_k        = 0;
    end else if (m_scanning) begin
      m_k++;
    end
    if (m_scanning && (m_k % ROWP == 1)) m_data = m_active[8*((m_k / ROWP) % NR) +: 8];
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) step(1'b0, '0, a);
  endtask

  initial begin
    logic [8*NR-1:0] frame_a;
    logic [8*NR-1:0] frame_b;
    logic [8*NR-1:0] frame_c;
    logic [8*NR-1:0] frame_d;

    bus.frame_valid = 1'b0;
    bus.frame       = '0;
    model_reset();

    // Reset held 3 cycles, then idle with no frame offered.
    @(negedge clk);
    do_reset(3);
    idle(5);

    // Frame A: row r = 1 << r; one full frame plus wrap into the next.
    for (int r = 0; r < NR; r++) frame_a[8*r +: 8] = 8'(1 << r);
    step(1'b1, frame_a, acc);
    idle(FRAMEP + 20);

    // Frame B mid-frame, then frame C held until the shadow frees up.
    frame_b = {NR{8'hAA}};
    frame_c = {$urandom, $urandom};
    step(1'b1, frame_b, acc);
    for (int i = 0; i < 3 * FRAMEP; i++) begin
      step(1'b1, frame_c, acc);
      if (acc) break;
    end
    idle(2 * FRAMEP + 10);

    // Random offers with random valid gaps.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) == 0), {$urandom, $urandom}, acc);
    end

    // Reset during SHOW of row 3; nothing displays until a new frame arrives.
    for (int i = 0; i < 2 * FRAMEP; i++) begin
      if (m_scanning && ((m_k / ROWP) % NR == 3) && (m_k % ROWP == 2)) break;
      step(1'b0, '0, acc);
    end
    do_reset(1);
    idle(20);
    frame_d = {$urandom, $urandom};
    step(1'b1, frame_d, acc);
    idle(FRAMEP + 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
